// File: rtl/scan_counter_7seg.sv
// Prescaled up/down hex or BCD counter with a multiplexed, active-low 7-segment display.
// The display shows each digit for SCAN_DIV cycles and lags the count by one cycle.
module scan_counter_7seg #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned TICK_DIV = 10,
  parameter int unsigned SCAN_DIV = 4,
  parameter bit          BCD_MODE = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  upDown,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   loadValue,
  output logic [4*DIGITS-1:0]   count,
  output logic                  wrap,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg7
);

  localparam int unsigned CW   = 4 * DIGITS;
  localparam int unsigned PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [3:0]  DMAX = BCD_MODE ? 4'd9 : 4'd15;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'h0:    seg_decode = 7'b0000001;
      4'h1:    seg_decode = 7'b1001111;
      4'h2:    seg_decode = 7'b0010010;
      4'h3:    seg_decode = 7'b0000110;
      4'h4:    seg_decode = 7'b1001100;
      4'h5:    seg_decode = 7'b0100100;
      4'h6:    seg_decode = 7'b0100000;
      4'h7:    seg_decode = 7'b0001111;
      4'h8:    seg_decode = 7'b0000000;
      4'h9:    seg_decode = 7'b0000100;
      4'hA:    seg_decode = 7'b0001000;
      4'hB:    seg_decode = 7'b1100000;
      4'hC:    seg_decode = 7'b0110001;
      4'hD:    seg_decode = 7'b1000010;
      4'hE:    seg_decode = 7'b0110000;
      default: seg_decode = 7'b0111000;
    endcase
  endfunction

  logic [PW-1:0]     presc_q, presc_d;
  logic [SW-1:0]     scan_q, scan_d;
  logic [IW-1:0]     dig_q, dig_d;
  logic [CW-1:0]     count_q, count_d;
  logic              wrap_q, wrap_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [6:0]        seg_q, seg_d;

  logic              tick;
  logic [CW-1:0]     step_val;
  logic              carry;
  logic [CW-1:0]     load_val;
  logic [3:0]        dig_v;
  logic [3:0]        ld_v;
  logic [3:0]        sel_dig;

  // Digit-serial step; the carry/borrow out of the top digit is the wrap condition.
  always_comb begin
    step_val = count_q;
    carry    = 1'b1;
    dig_v    = 4'd0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      dig_v = count_q[4*i +: 4];
      if (carry) begin
        if (upDown) begin
          if (dig_v == DMAX) begin
            dig_v = 4'd0;
          end else begin
            dig_v = dig_v + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (dig_v == 4'd0) begin
            dig_v = DMAX;
          end else begin
            dig_v = dig_v - 4'd1;
            carry = 1'b0;
          end
        end
      end
      step_val[4*i +: 4] = dig_v;
    end
  end

  // In BCD mode loaded digits above 9 saturate to 9.
  always_comb begin
    load_val = loadValue;
    ld_v     = 4'd0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      ld_v = loadValue[4*i +: 4];
      if (BCD_MODE && (ld_v > 4'd9)) begin
        ld_v = 4'd9;
      end
      load_val[4*i +: 4] = ld_v;
    end
  end

  assign tick = enable && (presc_q == PW'(TICK_DIV - 1));

  always_comb begin
    presc_d = presc_q;
    count_d = count_q;
    wrap_d  = 1'b0;
    scan_d  = scan_q;
    dig_d   = dig_q;
    sel_dig = 4'd0;

    if (load) begin
      count_d = load_val;
      presc_d = '0;
    end else if (enable) begin
      if (tick) begin
        presc_d = '0;
        count_d = step_val;
        wrap_d  = carry;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end

    // Scanning is independent of enable and load.
    if (scan_q == SW'(SCAN_DIV - 1)) begin
      scan_d = '0;
      dig_d  = (dig_q == IW'(DIGITS - 1)) ? '0 : dig_q + IW'(1);
    end else begin
      scan_d = scan_q + SW'(1);
    end

    for (int i = 0; i < int'(DIGITS); i++) begin
      if (dig_d == IW'(i)) begin
        sel_dig = count_q[4*i +: 4];
      end
    end
    an_d  = ~(DIGITS'(1) << dig_d);
    seg_d = seg_decode(sel_dig);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      scan_q  <= '0;
      dig_q   <= '0;
      count_q <= '0;
      wrap_q  <= 1'b0;
      an_q    <= ~DIGITS'(1);
      seg_q   <= 7'b0000001;
    end else begin
      presc_q <= presc_d;
      scan_q  <= scan_d;
      dig_q   <= dig_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign an    = an_q;
  assign seg7  = seg_q;

endmodule

// File: tb/tb_scan_counter_7seg.sv
// Directed bench: hex, BCD and single-digit instances share one stimulus stream.
module tb_scan_counter_7seg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       upDown = 1'b1;
  logic       load = 1'b0;
  logic [7:0] loadValue = 8'h00;

  logic [7:0] cnt_h, cnt_b;
  logic [3:0] cnt_1;
  logic       wrap_h, wrap_b, wrap_1;
  logic [1:0] an_h, an_b;
  logic [0:0] an_1;
  logic [6:0] seg_h, seg_b, seg_1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  scan_counter_7seg #(.DIGITS(2), .TICK_DIV(10), .SCAN_DIV(4), .BCD_MODE(1'b0)) u_hex (
    .clk(clk), .rst(rst), .enable(enable), .upDown(upDown), .load(load),
    .loadValue(loadValue), .count(cnt_h), .wrap(wrap_h), .an(an_h), .seg7(seg_h));

  scan_counter_7seg #(.DIGITS(2), .TICK_DIV(10), .SCAN_DIV(4), .BCD_MODE(1'b1)) u_bcd (
    .clk(clk), .rst(rst), .enable(enable), .upDown(upDown), .load(load),
    .loadValue(loadValue), .count(cnt_b), .wrap(wrap_b), .an(an_b), .seg7(seg_b));

  scan_counter_7seg #(.DIGITS(1), .TICK_DIV(10), .SCAN_DIV(4), .BCD_MODE(1'b0)) u_one (
    .clk(clk), .rst(rst), .enable(enable), .upDown(upDown), .load(load),
    .loadValue(loadValue[3:0]), .count(cnt_1), .wrap(wrap_1), .an(an_1), .seg7(seg_1));

  typedef struct {
    logic [3:0] v;
    logic [6:0] hseg;
    logic [3:0] bv;
    logic [6:0] bseg;
  } dec_vec_t;

  dec_vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; load = 1'b0; enable = 1'b0; upDown = 1'b1; loadValue = 8'h00;
    cyc(1);
    rst = 1'b0;
  endtask

  task automatic load_val(input logic [7:0] v);
    load = 1'b1; loadValue = v;
    cyc(1);
    load = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_cnt_h"}, 32'(cnt_h), 32'h00);
    chk({tag, "_cnt_b"}, 32'(cnt_b), 32'h00);
    chk({tag, "_wrap_h"}, 32'(wrap_h), 32'h0);
    chk({tag, "_an_h"}, 32'(an_h), 32'b10);
    chk({tag, "_seg_h"}, 32'(seg_h), 32'b0000001);
    chk({tag, "_an_1"}, 32'(an_1), 32'h0);
  endtask

  initial begin
    vecs[0]  = '{4'h0, 7'b0000001, 4'h0, 7'b0000001};
    vecs[1]  = '{4'h1, 7'b1001111, 4'h1, 7'b1001111};
    vecs[2]  = '{4'h2, 7'b0010010, 4'h2, 7'b0010010};
    vecs[3]  = '{4'h3, 7'b0000110, 4'h3, 7'b0000110};
    vecs[4]  = '{4'h4, 7'b1001100, 4'h4, 7'b1001100};
    vecs[5]  = '{4'h5, 7'b0100100, 4'h5, 7'b0100100};
    vecs[6]  = '{4'h6, 7'b0100000, 4'h6, 7'b0100000};
    vecs[7]  = '{4'h7, 7'b0001111, 4'h7, 7'b0001111};
    vecs[8]  = '{4'h8, 7'b0000000, 4'h8, 7'b0000000};
    vecs[9]  = '{4'h9, 7'b0000100, 4'h9, 7'b0000100};
    vecs[10] = '{4'hA, 7'b0001000, 4'h9, 7'b0000100};
    vecs[11] = '{4'hB, 7'b1100000, 4'h9, 7'b0000100};
    vecs[12] = '{4'hC, 7'b0110001, 4'h9, 7'b0000100};
    vecs[13] = '{4'hD, 7'b1000010, 4'h9, 7'b0000100};
    vecs[14] = '{4'hE, 7'b0110000, 4'h9, 7'b0000100};
    vecs[15] = '{4'hF, 7'b0111000, 4'h9, 7'b0000100};

    // Reset held 3 cycles, then hex/BCD count-up.
    rst = 1'b1;
    cyc(3);
    chk_reset_state("rst3");
    rst = 1'b0; enable = 1'b1; upDown = 1'b1;
    cyc(1);
    chk("up_e1_h", 32'(cnt_h), 32'h00);
    cyc(8);
    chk("up_e9_h", 32'(cnt_h), 32'h00);
    cyc(1);
    chk("up_e10_h", 32'(cnt_h), 32'h01);
    chk("up_e10_b", 32'(cnt_b), 32'h01);
    cyc(140);
    chk("up_e150_h", 32'(cnt_h), 32'h0F);
    chk("up_e150_b", 32'(cnt_b), 32'h15);
    chk("up_e150_1", 32'(cnt_1), 32'hF);
    cyc(2);
    chk("up_e152_an", 32'(an_h), 32'b10);
    chk("up_e152_seg_h", 32'(seg_h), 32'b0111000);
    chk("up_e152_seg_b", 32'(seg_b), 32'b0100100);
    chk("up_e152_seg_1", 32'(seg_1), 32'b0111000);

    // Decoder and BCD load saturation, digit 0 shown on the second edge after reset.
    for (int i = 0; i < 16; i++) begin
      do_reset();
      load_val({4'h0, vecs[i].v});
      cyc(1);
      chk($sformatf("dec%0d_cnt_h", i), 32'(cnt_h), 32'({4'h0, vecs[i].v}));
      chk($sformatf("dec%0d_cnt_b", i), 32'(cnt_b), 32'({4'h0, vecs[i].bv}));
      chk($sformatf("dec%0d_seg_h", i), 32'(seg_h), 32'(vecs[i].hseg));
      chk($sformatf("dec%0d_seg_b", i), 32'(seg_b), 32'(vecs[i].bseg));
      chk($sformatf("dec%0d_seg_1", i), 32'(seg_1), 32'(vecs[i].hseg));
      chk($sformatf("dec%0d_an_h", i), 32'(an_h), 32'b10);
    end

    // Count down from zero wraps to all-max.
    do_reset();
    enable = 1'b1; upDown = 1'b0;
    cyc(9);
    chk("dn_e9_h", 32'(cnt_h), 32'h00);
    chk("dn_e9_wrap", 32'(wrap_h), 32'h0);
    cyc(1);
    chk("dn_e10_h", 32'(cnt_h), 32'hFF);
    chk("dn_e10_wrap_h", 32'(wrap_h), 32'h1);
    chk("dn_e10_b", 32'(cnt_b), 32'h99);
    chk("dn_e10_wrap_b", 32'(wrap_b), 32'h1);
    cyc(1);
    chk("dn_e11_wrap_h", 32'(wrap_h), 32'h0);
    chk("dn_e11_wrap_b", 32'(wrap_b), 32'h0);
    cyc(9);
    chk("dn_e20_h", 32'(cnt_h), 32'hFE);
    chk("dn_e20_b", 32'(cnt_b), 32'h98);

    // BCD borrow 10 -> 09.
    do_reset();
    load_val(8'h10);
    enable = 1'b1; upDown = 1'b0;
    cyc(10);
    chk("borrow_b", 32'(cnt_b), 32'h09);
    chk("borrow_h", 32'(cnt_h), 32'h0F);

    // BCD wrap 99 -> 00 with a single-cycle pulse.
    do_reset();
    load_val(8'h99);
    enable = 1'b1; upDown = 1'b1;
    cyc(9);
    chk("bw_e9_b", 32'(cnt_b), 32'h99);
    chk("bw_e9_wrap", 32'(wrap_b), 32'h0);
    cyc(1);
    chk("bw_e10_b", 32'(cnt_b), 32'h00);
    chk("bw_e10_wrap_b", 32'(wrap_b), 32'h1);
    chk("bw_e10_h", 32'(cnt_h), 32'h9A);
    chk("bw_e10_wrap_h", 32'(wrap_h), 32'h0);
    cyc(1);
    chk("bw_e11_wrap_b", 32'(wrap_b), 32'h0);

    // BCD carry 09 -> 10.
    do_reset();
    load_val(8'h09);
    enable = 1'b1; upDown = 1'b1;
    cyc(10);
    chk("carry_b", 32'(cnt_b), 32'h10);
    chk("carry_h", 32'(cnt_h), 32'h0A);

    // Hex wrap FF -> 00; BCD stored 99 and single digit stored F.
    do_reset();
    load_val(8'hFF);
    chk("hw_ld_b", 32'(cnt_b), 32'h99);
    enable = 1'b1; upDown = 1'b1;
    cyc(10);
    chk("hw_h", 32'(cnt_h), 32'h00);
    chk("hw_wrap_h", 32'(wrap_h), 32'h1);
    chk("hw_wrap_b", 32'(wrap_b), 32'h1);
    chk("hw_wrap_1", 32'(wrap_1), 32'h1);

    // Enable low freezes count and prescaler while scanning continues.
    do_reset();
    enable = 1'b1; upDown = 1'b1;
    cyc(5);
    enable = 1'b0;
    cyc(3);
    chk("en_e8_an", 32'(an_h), 32'b10);
    cyc(4);
    chk("en_e12_an", 32'(an_h), 32'b01);
    cyc(4);
    chk("en_e16_an", 32'(an_h), 32'b10);
    chk("en_e16_an_1", 32'(an_1), 32'h0);
    cyc(14);
    chk("en_e30_cnt", 32'(cnt_h), 32'h00);
    enable = 1'b1;
    cyc(4);
    chk("en_resume4", 32'(cnt_h), 32'h00);
    cyc(1);
    chk("en_resume5", 32'(cnt_h), 32'h01);

    // Load on a tick cycle overrides the step and clears the prescaler.
    do_reset();
    enable = 1'b1; upDown = 1'b1;
    cyc(9);
    load = 1'b1; loadValue = 8'h3A;
    cyc(1);
    load = 1'b0;
    chk("lt_b", 32'(cnt_b), 32'h39);
    chk("lt_h", 32'(cnt_h), 32'h3A);
    chk("lt_wrap", 32'(wrap_h), 32'h0);
    cyc(9);
    chk("lt_e9_b", 32'(cnt_b), 32'h39);
    cyc(1);
    chk("lt_e10_b", 32'(cnt_b), 32'h40);
    chk("lt_e10_h", 32'(cnt_h), 32'h3B);

    // Reset mid-count with digit 1 selected beats a pending tick and load.
    do_reset();
    enable = 1'b1; upDown = 1'b1;
    cyc(29);
    chk("mr_pre_cnt", 32'(cnt_h), 32'h02);
    chk("mr_pre_an", 32'(an_h), 32'b01);
    rst = 1'b1; load = 1'b1; loadValue = 8'h55;
    cyc(1);
    chk_reset_state("mr");
    chk("mr_wrap_b", 32'(wrap_b), 32'h0);
    rst = 1'b0; load = 1'b0;
    cyc(9);
    chk("mr_e9", 32'(cnt_h), 32'h00);
    cyc(1);
    chk("mr_e10", 32'(cnt_h), 32'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
